// File: rtl/captura_digitos.sv
// Keypad digit capture: assembles up to two BCD digits
// and flags the committed entry for the concatenation stage.
module captura_digitos #(
    parameter logic [3:0] KEY_CLEAR = 4'hC,
    parameter logic [3:0] KEY_ENTER = 4'hE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic [3:0] dec,
    output logic [3:0] uni,
    output logic [1:0] digit_cnt,
    output logic       num_ready,
    output logic       num_strobe
);

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        UNO   = 2'd1,
        DOS   = 2'd2,
        LISTO = 2'd3
    } state_t;

    state_t state;
    logic   kv_q;
    logic   accept;
    logic   is_dig;
    logic   is_clr;
    logic   is_ent;

    // Rising edge of key_valid; key classification
    always_comb begin
        accept = key_valid & ~kv_q;
        is_dig = (key_code <= 4'd9);
        is_clr = (key_code == KEY_CLEAR);
        is_ent = (key_code == KEY_ENTER);
    end

    // Entry FSM with registered digit and flag outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= VACIO;
            kv_q       <= 1'b1;
            dec        <= 4'h0;
            uni        <= 4'h0;
            digit_cnt  <= 2'd0;
            num_ready  <= 1'b0;
            num_strobe <= 1'b0;
        end else begin
            kv_q       <= key_valid;
            num_strobe <= 1'b0;
            if (accept) begin
                if (is_clr) begin
                    state     <= VACIO;
                    dec       <= 4'h0;
                    uni       <= 4'h0;
                    digit_cnt <= 2'd0;
                    num_ready <= 1'b0;
                end else begin
                    unique case (state)
                        VACIO, LISTO: begin
                            if (is_dig) begin
                                state     <= UNO;
                                dec       <= 4'h0;
                                uni       <= key_code;
                                digit_cnt <= 2'd1;
                                num_ready <= 1'b0;
                            end
                        end
                        UNO: begin
                            if (is_dig) begin
                                state     <= DOS;
                                dec       <= uni;
                                uni       <= key_code;
                                digit_cnt <= 2'd2;
                            end else if (is_ent) begin
                                state      <= LISTO;
                                num_ready  <= 1'b1;
                                num_strobe <= 1'b1;
                            end
                        end
                        DOS: begin
                            if (is_ent) begin
                                state      <= LISTO;
                                num_ready  <= 1'b1;
                                num_strobe <= 1'b1;
                            end
                        end
                        default: state <= VACIO;
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/captura_digitos.md
# captura_digitos

Keypad digit-capture stage sitting directly upstream of the decimal-to-binary concatenation stage. Accepts decoded key codes from the keypad scanner/debouncer, assembles up to two decimal digits into a tens digit and a units digit, and presents them as `dec`/`uni`, with a completion flag once the user presses ENTER. Single-digit entries are right-aligned (tens = 0), so the downstream stage always sees a valid 0–99 BCD pair.

## Interface
- `KEY_CLEAR`, default 4'hC: key code that aborts entry and zeroes the digits.
- `KEY_ENTER`, default 4'hE: key code that commits the current entry.
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `key_code`  input  4  decoded key. 0–9 are digits, `KEY_CLEAR`/`KEY_ENTER` are commands, all other codes are ignored.
- `key_valid`  input  1  high while a debounced key is pressed. May stay high for many cycles.
- `dec`  output  4  captured tens digit, BCD 0–9.
- `uni`  output  4  captured units digit, BCD 0–9.
- `digit_cnt`  output  2  digits held in the current entry (0, 1, 2).
- `num_ready`  output  1  level flag: entry committed, `dec`/`uni` stable.
- `num_strobe`  output  1  one-cycle pulse on the cycle after commit.

## Operation
- **Key acceptance:** internal register `kv_q` holds the previous `key_valid`. A key is accepted only on the edge where `key_valid=1` and `kv_q=0`. Holding a key accepts it once. `key_code` is sampled on that same edge.
- **States:** VACIO (0 digits), UNO (1 digit), DOS (2 digits), LISTO (committed).

**Transitions on an accepted key** (anything not listed holds state and outputs):
- **VACIO:**
  - digit d → UNO, `uni=d`, `dec=0`.
  - ENTER → ignored.
  - CLEAR → VACIO.
- **UNO:**
  - digit d → DOS, `dec=uni`, `uni=d`.
  - ENTER → LISTO.
  - CLEAR → VACIO, `dec=uni=0`.
- **DOS:**
  - digit → ignored; the entry is saturated at two digits.
  - ENTER → LISTO.
  - CLEAR → VACIO, `dec=uni=0`.
- **LISTO:**
  - digit d → UNO, `dec=0`, `uni=d`. This starts a new entry and drops `num_ready`.
  - CLEAR → VACIO, `dec=uni=0`.
  - ENTER → ignored; no second strobe.

**Outputs:**
- `digit_cnt`: 0 in VACIO, 1 in UNO, 2 in DOS. In LISTO it keeps the count of the committed entry.
- `num_ready` = 1 exactly while in LISTO.
- `num_strobe` = 1 for exactly the one cycle in which the FSM first occupies LISTO.

**Width/arithmetic:** digits are stored unmodified, with no conversion. Non-digit codes 0xA–0xF other than the two commands cause no change.

## Timing
- **Reset:** `rst_n=0` sampled at a rising edge forces, at that edge:
  - state VACIO, `kv_q=1`, `dec=4'h0`, `uni=4'h0`, `digit_cnt=2'd0`, `num_ready=0`, `num_strobe=0`.
- `kv_q=1` on reset means a key already held through reset release is not accepted until it is released and pressed again.
- **Reset mid-entry** (any state) discards the entry with the same values. No strobe.
- **Latency:** all outputs are registered. An accepted key at edge N is reflected on the outputs after edge N (one-cycle latency from the sampled press).
- **Commit:** `num_strobe` and `num_ready` rise together after the ENTER edge. `num_strobe` falls after the next edge; `num_ready` holds.
- **Back-to-back keys:** `key_valid` must be low for at least one cycle between presses. Two presses separated by a single low cycle are both accepted.
- **Simultaneous reset and key:** reset wins and the key is dropped.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `key_valid=1`, `key_code=5`, then release.
  - Required: `dec=0`, `uni=0`, `digit_cnt=0`, `num_ready=0`, and no capture until `key_valid` drops and rises again.
- **Two-digit entry:** press 4, then 2, then ENTER.
  - Required: after the first press `uni=4`, `dec=0`, `digit_cnt=1`; after the second `dec=4`, `uni=2`, `digit_cnt=2`.
  - After ENTER, `num_strobe` is high for exactly 1 cycle and `num_ready=1` holds. Downstream stage yields `num=0101010` (42).
- **Single digit and held key:** press 7 and hold `key_valid` for 10 cycles, then ENTER.
  - Required: only one capture, giving `dec=0`, `uni=7`, `num_ready=1`.
- **Saturation:** press 9, 9, 3, ENTER.
  - Required: `dec=9`, `uni=9`, and the third digit is ignored (`digit_cnt` stays 2).
- **Clear and restart:**
  - Press 1, 5, CLEAR → `dec=0`, `uni=0`, `digit_cnt=0`.
  - ENTER in VACIO → no strobe.
  - Then 3, ENTER, 8 → `num_ready` drops, `uni=8`, `dec=0`, `digit_cnt=1`.
- **Ignored codes and repeated ENTER:**
  - Press 4'hA, 4'hF in UNO → no change.
  - ENTER twice → exactly one `num_strobe` pulse.
